riscv_apu_disp_multi: RTL and testbench
=======================================

Name: riscv_apu_disp_multi

Overview:
- Parametrised in-order APU dispatcher.
- Tracks up to DEPTH outstanding multicycle APU requests in a circular FIFO. Generalises the fixed two-slot inflight/waiting scheme.
- Generates req/ready handshakes, latency-class ordering stalls, capacity stalls, read/write dependency flags, and writeback register addresses.
- Sits between ID stage and the APU interconnect; responses always return in issue order.

Parameters:
DEPTH, 4, max outstanding multicycle requests (power of 2, >=2)
ADDR_W, 6, register address width
NREAD, 3, read-register ports checked for RAW dependencies
NWRITE, 2, write-register ports checked for WAW dependencies

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
setback_i  in  1  synchronous flush of all tracking state
enable_i  in  1  ID has an APU instruction
apu_lat_i  in  2  latency class of request (0..3)
apu_waddr_i  in  ADDR_W  destination register of request
apu_waddr_o  out  ADDR_W  destination of returning result
apu_multicycle_o  out  1  last class multicycle, or class 0 with entries outstanding
apu_singlecycle_o  out  1  FIFO empty
active_o  out  1  FIFO non-empty
stall_o  out  1  stall_type | stall_full | stall_nack
is_decoding_i  in  1  qualifies dependency outputs
read_regs_i  in  NREAD*ADDR_W  read register addresses
read_regs_valid_i  in  NREAD  per-port valid
read_dep_o  out  1  RAW hazard
write_regs_i  in  NWRITE*ADDR_W  write register addresses
write_regs_valid_i  in  NWRITE  per-port valid
write_dep_o  out  1  WAW hazard
perf_type_o  out  1  stall_type
perf_cont_o  out  1  stall_nack | stall_full
occupancy_o  out  $clog2(DEPTH)+1  outstanding count
err_o  out  1  sticky spurious-response flag (see feature)
apu_master_req_o  out  1  request valid
apu_master_ready_o  out  1  constant 1
apu_master_gnt_i  in  1  request grant
apu_master_valid_i  in  1  result valid

Behaviour:
- Reset (async) and setback_i (sync):
  - Clears FIFO: head=tail=0, count=0, all entry valids 0.
  - Clears last_lat to 0 and err flag to 0.
  - Outputs after reset: active_o=0, singlecycle_o=1, multicycle_o=0, occupancy_o=0, err_o=0, apu_waddr_o=0.
- active = count!=0; full = count==DEPTH.
- stall_type = enable_i & active & (lat_i==1 | lat_i==0 | last_lat==0 | (lat_i==2 & last_lat==3)).
- stall_full = enable_i & full & !apu_master_valid_i. A same-cycle pop frees a slot.
- valid_req = enable_i & !stall_type & !stall_full; apu_master_req_o = valid_req.
- stall_nack = valid_req & !apu_master_gnt_i.
- accepted = valid_req & gnt.
- last_lat <= apu_lat_i on every valid_req.
- Response handling:
  - Response with count==0 and valid_req set is a single-cycle return. apu_waddr_o=apu_waddr_i; nothing pushed.
  - Response with count>0 pops head. apu_waddr_o=entry[head].addr; head wraps modulo DEPTH.
  - Otherwise apu_waddr_o=0.
- accepted and not a single-cycle return: push apu_waddr_i at tail; tail wraps modulo DEPTH.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Dependencies:
  - read_dep_o = is_decoding_i & OR over all matches (port valid & address equal) against:
    - each valid FIFO entry, excluding head when it pops this cycle;
    - addr_req when valid_req and not a single-cycle return.
  - write_dep_o uses the same rule on write ports.
- Response with count==0 and !valid_req: no state change; waddr 0; handled per feature.

Optional Feature:
APU_DISP_ERR_EN
- Defined: err_o is set sticky on apu_master_valid_i & count==0 & !valid_req. Cleared only by reset or setback_i.
- Undefined: err_o tied 0; no extra flops.

Test Plan:
- DEPTH=4; issue 4 granted lat=3 requests to r1..r4, no responses -> occupancy 4. 5th enable_i gives stall_o=1, perf_cont_o=1, req_o=0.
- Full FIFO, 5th request same cycle as response -> response pops r1 (waddr_o=1); r5 pushed; occupancy stays 4.
- Empty FIFO, lat=1 request with gnt and valid same cycle -> waddr_o=apu_waddr_i; occupancy stays 0.
- Outstanding r7, lat=2 request while last_lat=3 -> stall_type=1, perf_type_o=1. read_regs_i[0]=7 valid with is_decoding_i -> read_dep_o=1. Same cycle as r7's return -> read_dep_o=0.
- setback_i with 3 outstanding -> next cycle occupancy 0, active_o=0, singlecycle_o=1.
- With APU_DISP_ERR_EN, valid_i pulse while empty and no request -> err_o=1 and holds until setback_i.

Source files
------------

// File: rtl/riscv_apu_disp_multi.sv
// riscv_apu_disp_multi: in-order APU dispatcher tracking up to DEPTH outstanding multicycle requests
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   setback_i                synchronous flush of all tracking state
//   enable_i, apu_lat_i,     request from ID: valid, latency class, destination register
//   apu_waddr_i
//   apu_waddr_o              destination register of the result returning this cycle
//   apu_multicycle_o         last class was multicycle, or class 0 with entries outstanding
//   apu_singlecycle_o        nothing outstanding
//   active_o                 something outstanding
//   stall_o                  ID must hold (ordering, capacity or no grant)
//   is_decoding_i            qualifies dependency outputs
//   read_regs_i/_valid_i     read ports checked for RAW hazards -> read_dep_o
//   write_regs_i/_valid_i    write ports checked for WAW hazards -> write_dep_o
//   perf_type_o, perf_cont_o stall reason counters (ordering / contention)
//   occupancy_o              outstanding request count
//   err_o                    sticky spurious-response flag
//   apu_master_*             request/grant/result handshake to the APU interconnect
//
// Build option: define APU_DISP_ERR_EN to enable the sticky err_o flag; otherwise err_o is 0.
module riscv_apu_disp_multi #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int NREAD  = 3,
    parameter int NWRITE = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     setback_i,
    input  logic                     enable_i,
    input  logic [1:0]               apu_lat_i,
    input  logic [ADDR_W-1:0]        apu_waddr_i,
    output logic [ADDR_W-1:0]        apu_waddr_o,
    output logic                     apu_multicycle_o,
    output logic                     apu_singlecycle_o,
    output logic                     active_o,
    output logic                     stall_o,
    input  logic                     is_decoding_i,
    input  logic [NREAD*ADDR_W-1:0]  read_regs_i,
    input  logic [NREAD-1:0]         read_regs_valid_i,
    output logic                     read_dep_o,
    input  logic [NWRITE*ADDR_W-1:0] write_regs_i,
    input  logic [NWRITE-1:0]        write_regs_valid_i,
    output logic                     write_dep_o,
    output logic                     perf_type_o,
    output logic                     perf_cont_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     err_o,
    output logic                     apu_master_req_o,
    output logic                     apu_master_ready_o,
    input  logic                     apu_master_gnt_i,
    input  logic                     apu_master_valid_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count;
    logic [1:0]        last_lat;
    logic active, full, stall_type, stall_full, stall_nack, valid_req, single_ret, pop, push_req, push;
    logic rd_hit, wr_hit;

    assign active     = count != '0;
    assign full       = count == CW'(DEPTH);
    assign stall_type = enable_i & active & (apu_lat_i == 2'd1 | apu_lat_i == 2'd0 | last_lat == 2'd0 |
                                             (apu_lat_i == 2'd2 & last_lat == 2'd3));
    // a response in the same cycle frees the head slot, so a full FIFO may still accept
    assign stall_full = enable_i & full & ~apu_master_valid_i;
    assign valid_req  = enable_i & ~stall_type & ~stall_full;
    assign stall_nack = valid_req & ~apu_master_gnt_i;
    // result arrives alongside its own request: forwarded, never stored
    assign single_ret = apu_master_valid_i & ~active & valid_req;
    assign pop        = apu_master_valid_i & active;
    assign push_req   = valid_req & ~single_ret;
    assign push       = push_req & apu_master_gnt_i;

    assign apu_master_req_o   = valid_req;
    assign apu_master_ready_o = 1'b1;
    assign stall_o            = stall_type | stall_full | stall_nack;
    assign perf_type_o        = stall_type;
    assign perf_cont_o        = stall_nack | stall_full;
    assign active_o           = active;
    assign apu_singlecycle_o  = ~active;
    assign apu_multicycle_o   = last_lat == 2'd3 | (last_lat == 2'd0 & active);
    assign occupancy_o        = count;
    assign apu_waddr_o        = single_ret ? apu_waddr_i : pop ? addr_q[head] : '0;
    assign read_dep_o         = is_decoding_i & rd_hit;
    assign write_dep_o        = is_decoding_i & wr_hit;

    // the head entry retiring this cycle no longer blocks; the request being issued does
    always_comb begin
        rd_hit = 1'b0;
        wr_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !(pop && head == PW'(i))) begin
                for (int r = 0; r < NREAD; r++)
                    if (read_regs_valid_i[r] && read_regs_i[r*ADDR_W +: ADDR_W] == addr_q[i]) rd_hit = 1'b1;
                for (int w = 0; w < NWRITE; w++)
                    if (write_regs_valid_i[w] && write_regs_i[w*ADDR_W +: ADDR_W] == addr_q[i]) wr_hit = 1'b1;
            end
        end
        if (push_req) begin
            for (int r = 0; r < NREAD; r++)
                if (read_regs_valid_i[r] && read_regs_i[r*ADDR_W +: ADDR_W] == apu_waddr_i) rd_hit = 1'b1;
            for (int w = 0; w < NWRITE; w++)
                if (write_regs_valid_i[w] && write_regs_i[w*ADDR_W +: ADDR_W] == apu_waddr_i) wr_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            valid_q  <= '0;
            last_lat <= 2'd0;
            for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else if (setback_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            valid_q  <= '0;
            last_lat <= 2'd0;
        end else begin
            if (valid_req) last_lat <= apu_lat_i;
            // pop before push: when full, head==tail and the new entry must stay valid
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (push) begin
                addr_q[tail]  <= apu_waddr_i;
                valid_q[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef APU_DISP_ERR_EN
    logic err_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                        err_q <= 1'b0;
        else if (setback_i)                                 err_q <= 1'b0;
        else if (apu_master_valid_i & ~active & ~valid_req) err_q <= 1'b1;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_apu_disp_multi.sv
// tb_riscv_apu_disp_multi: table, directed and random checks of the APU dispatcher against a queue model
module tb_riscv_apu_disp_multi;
    localparam int DEPTH = 4;
    localparam int AW    = 6;
    localparam int NR    = 3;
    localparam int NW    = 2;

    logic clk = 0;
    logic rst_n = 0;
    logic setback = 0, en = 0, is_dec = 0, gnt = 0, val = 0;
    logic [1:0] lat = 0;
    logic [AW-1:0] wa = 0;
    logic [NR*AW-1:0] rr = 0;
    logic [NR-1:0] rv = 0;
    logic [NW*AW-1:0] wr = 0;
    logic [NW-1:0] wv = 0;
    logic [AW-1:0] waddr_o;
    logic multi_o, single_o, active_o, stall_o, rdep_o, wdep_o, ptype_o, pcont_o, err_o, req_o, ready_o;
    logic [2:0] occ_o;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] mq[$];
    logic [1:0] mlast = 0;
    bit merr = 0;

    always #5 clk = ~clk;

    riscv_apu_disp_multi #(.DEPTH(DEPTH), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .setback_i(setback), .enable_i(en), .apu_lat_i(lat),
        .apu_waddr_i(wa), .apu_waddr_o(waddr_o), .apu_multicycle_o(multi_o),
        .apu_singlecycle_o(single_o), .active_o(active_o), .stall_o(stall_o),
        .is_decoding_i(is_dec), .read_regs_i(rr), .read_regs_valid_i(rv), .read_dep_o(rdep_o),
        .write_regs_i(wr), .write_regs_valid_i(wv), .write_dep_o(wdep_o),
        .perf_type_o(ptype_o), .perf_cont_o(pcont_o), .occupancy_o(occ_o), .err_o(err_o),
        .apu_master_req_o(req_o), .apu_master_ready_o(ready_o),
        .apu_master_gnt_i(gnt), .apu_master_valid_i(val)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rhit(input logic [AW-1:0] a);
        for (int r = 0; r < NR; r++) if (rv[r] && rr[r*AW +: AW] == a) return 1;
        return 0;
    endfunction

    function automatic bit whit(input logic [AW-1:0] a);
        for (int w = 0; w < NW; w++) if (wv[w] && wr[w*AW +: AW] == a) return 1;
        return 0;
    endfunction

    // inputs are set at the falling edge; check combinational + state outputs, then advance the model
    task automatic cycle();
        int n;
        bit act, full, st, sf, vr, nack, single, pop, rd, wd;
        logic [AW-1:0] ew;
        #1;
        n      = mq.size();
        act    = n != 0;
        full   = n == DEPTH;
        st     = en && act && (lat == 1 || lat == 0 || mlast == 0 || (lat == 2 && mlast == 3));
        sf     = en && full && !val;
        vr     = en && !st && !sf;
        nack   = vr && !gnt;
        single = val && n == 0 && vr;
        pop    = val && n > 0;
        ew     = single ? wa : pop ? mq[0] : '0;
        rd     = 0;
        wd     = 0;
        for (int k = pop ? 1 : 0; k < n; k++) begin
            rd |= rhit(mq[k]);
            wd |= whit(mq[k]);
        end
        if (vr && !single) begin
            rd |= rhit(wa);
            wd |= whit(wa);
        end
        chk("req", req_o, vr);
        chk("ready", ready_o, 1);
        chk("stall", stall_o, st || sf || nack);
        chk("perf_type", ptype_o, st);
        chk("perf_cont", pcont_o, sf || nack);
        chk("active", active_o, act);
        chk("singlecycle", single_o, !act);
        chk("multicycle", multi_o, mlast == 3 || (mlast == 0 && act));
        chk("occupancy", occ_o, n);
        chk("waddr", waddr_o, ew);
        chk("read_dep", rdep_o, is_dec && rd);
        chk("write_dep", wdep_o, is_dec && wd);
        chk("err", err_o, merr);
        @(posedge clk);
        if (setback) begin
            mq.delete();
            mlast = 0;
            merr  = 0;
        end else begin
            if (vr) mlast = lat;
            if (pop) void'(mq.pop_front());
            if (vr && gnt && !single) mq.push_back(wa);
`ifdef APU_DISP_ERR_EN
            if (val && n == 0 && !vr) merr = 1;
`endif
        end
        @(negedge clk);
    endtask

    task automatic idle();
        setback = 0; en = 0; lat = 0; wa = 0; gnt = 0; val = 0;
        is_dec = 0; rr = 0; rv = 0; wr = 0; wv = 0;
    endtask

    typedef struct {
        logic       sb, e, g, v;
        logic [1:0] l;
        logic [5:0] a;
        int         occ, stall, req, wad;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{0, 1, 1, 0, 3, 1, 0, 0, 1, 0};
        tbl[1]  = '{0, 1, 1, 0, 3, 2, 1, 0, 1, 0};
        tbl[2]  = '{0, 1, 1, 0, 3, 3, 2, 0, 1, 0};
        tbl[3]  = '{0, 1, 1, 0, 3, 4, 3, 0, 1, 0};
        tbl[4]  = '{0, 1, 1, 0, 3, 5, 4, 1, 0, 0};
        tbl[5]  = '{0, 1, 1, 1, 3, 5, 4, 0, 1, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 4, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 0, 0, 4, 0, 0, 2};
        tbl[8]  = '{0, 0, 0, 1, 0, 0, 3, 0, 0, 3};
        tbl[9]  = '{0, 0, 0, 1, 0, 0, 2, 0, 0, 4};
        tbl[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 5};
        tbl[11] = '{0, 1, 1, 1, 1, 9, 0, 0, 1, 9};
        tbl[12] = '{0, 1, 0, 0, 3, 6, 0, 1, 1, 0};
        tbl[13] = '{0, 1, 1, 0, 3, 6, 0, 0, 1, 0};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};

        idle();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1;
        chk("reset_active", active_o, 0);
        chk("reset_single", single_o, 1);
        chk("reset_multi", multi_o, 0);
        chk("reset_occ", occ_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_waddr", waddr_o, 0);
        cycle();

        foreach (tbl[i]) begin
            idle();
            setback = tbl[i].sb; en = tbl[i].e; gnt = tbl[i].g; val = tbl[i].v;
            lat = tbl[i].l; wa = tbl[i].a;
            #1;
            chk($sformatf("tbl%0d_occ", i), occ_o, tbl[i].occ);
            chk($sformatf("tbl%0d_stall", i), stall_o, tbl[i].stall);
            chk($sformatf("tbl%0d_req", i), req_o, tbl[i].req);
            chk($sformatf("tbl%0d_waddr", i), waddr_o, tbl[i].wad);
            cycle();
        end
        idle();
        #1;
        chk("after_setback_occ", occ_o, 0);
        cycle();

        // ordering stall and RAW hazard against outstanding r7, then against r7 as it retires
        idle(); en = 1; lat = 3; wa = 7; gnt = 1;
        cycle();
        idle(); en = 1; lat = 2; wa = 8; gnt = 1; is_dec = 1; rr[AW-1:0] = 7; rv = 3'b001;
        #1;
        chk("dep_stall", stall_o, 1);
        chk("dep_ptype", ptype_o, 1);
        chk("dep_req", req_o, 0);
        chk("dep_read", rdep_o, 1);
        cycle();
        val = 1;
        #1;
        chk("dep_ret_read", rdep_o, 0);
        chk("dep_ret_waddr", waddr_o, 7);
        cycle();

        // WAW hazard on the request being issued
        idle(); en = 1; lat = 3; wa = 12; gnt = 1; is_dec = 1; wr[2*AW-1:AW] = 12; wv = 2'b10;
        #1;
        chk("waw_issue", wdep_o, 1);
        cycle();

        // setback with three outstanding
        idle(); en = 1; lat = 3; gnt = 1; wa = 20;
        cycle();
        wa = 21;
        cycle();
        idle(); setback = 1;
        cycle();
        idle();
        #1;
        chk("sb_occ", occ_o, 0);
        chk("sb_active", active_o, 0);
        chk("sb_single", single_o, 1);
        cycle();

        // spurious response while empty
        idle(); val = 1;
        cycle();
        idle();
        repeat (2) cycle();
`ifdef APU_DISP_ERR_EN
        #1;
        chk("err_sticky", err_o, 1);
`endif
        setback = 1;
        cycle();
        idle();
        #1;
        chk("err_cleared", err_o, 0);
        cycle();

        for (int c = 0; c < 3000; c++) begin
            setback = ($urandom_range(0, 79) == 0);
            en      = ($urandom_range(0, 9) < 6);
            lat     = 2'($urandom_range(0, 3));
            wa      = AW'($urandom_range(0, 7));
            gnt     = ($urandom_range(0, 3) != 0);
            val     = ($urandom_range(0, 9) < 3);
            is_dec  = ($urandom_range(0, 3) != 0);
            rv      = NR'($urandom);
            wv      = NW'($urandom);
            for (int r = 0; r < NR; r++) rr[r*AW +: AW] = AW'($urandom_range(0, 7));
            for (int w = 0; w < NW; w++) wr[w*AW +: AW] = AW'($urandom_range(0, 7));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
